// File: rtl/write_stream_sequencer.sv
// Buffers a command's data beats and issues one single-word write per beat on a
// req/ack handshake, with addresses stepping by STRIDE; pulses done after the last ack.
module write_stream_sequencer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned STRIDE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_base_i,
    input  logic [15:0] cmd_count_i,
    input  logic        data_valid_i,
    output logic        data_ready_o,
    input  logic [31:0] data_i,
    output logic        fsm_req_o,
    output logic [31:0] fsm_adress_o,
    output logic [31:0] fsm_data_o,
    input  logic        fsm_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_n;
    logic [OW-1:0] occ;
    logic [OW-1:0] occ_pop;
    logic [OW-1:0] occ_n;
    logic [15:0]   rem_accept;
    logic [15:0]   rem_accept_n;
    logic [15:0]   rem_ack;
    logic          push;
    logic          pop;
    logic [31:0]   head_n;

    // Buffer bookkeeping; the presented beat stays in the buffer until acked.
    assign push         = data_valid_i && data_ready_o;
    assign pop          = fsm_ack_i && fsm_req_o;
    assign occ_pop      = occ - OW'(pop);
    assign occ_n        = occ_pop + OW'(push);
    assign rd_ptr_n     = rd_ptr + PW'(pop);
    assign rem_accept_n = rem_accept - 16'(push);
    // After a pop the new head is either an already-buffered beat or the beat arriving now.
    assign head_n       = (occ_pop == '0) ? data_i : mem[rd_ptr_n];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            rem_accept   <= '0;
            rem_ack      <= '0;
            cmd_ready_o  <= 1'b1;
            data_ready_o <= 1'b0;
            fsm_req_o    <= 1'b0;
            fsm_adress_o <= '0;
            fsm_data_o   <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        fsm_adress_o <= cmd_base_i;
                        rem_accept   <= cmd_count_i;
                        rem_ack      <= cmd_count_i;
                        err_o        <= 1'b0;
                        cmd_ready_o  <= 1'b0;
                        if (cmd_count_i == 16'd0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state        <= RUN;
                            busy_o       <= 1'b1;
                            data_ready_o <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (push) begin
                        wr_ptr <= wr_ptr + PW'(1);
                    end
                    occ          <= occ_n;
                    rd_ptr       <= rd_ptr_n;
                    rem_accept   <= rem_accept_n;
                    fsm_req_o    <= (occ_n != '0);
                    data_ready_o <= (occ_n < OW'(DEPTH)) && (rem_accept_n != 16'd0);
                    if (occ_n != '0) begin
                        fsm_data_o <= head_n;
                    end
                    if (pop) begin
                        fsm_adress_o <= fsm_adress_o + 32'(STRIDE);
                        rem_ack      <= rem_ack - 16'd1;
                        if (rem_ack == 16'd1) begin
                            state        <= DONE;
                            done_o       <= 1'b1;
                            busy_o       <= 1'b0;
                            data_ready_o <= 1'b0;
                            fsm_req_o    <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    cmd_ready_o <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    cmd_ready_o <= 1'b1;
                end
            endcase
            // A stray ack is flagged even if a command is being accepted this cycle.
            if (fsm_ack_i && !fsm_req_o) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_write_stream_sequencer.sv
// Bench for write_stream_sequencer: directed scenarios plus randomized commands,
// checked against an address/data list computed from base, stride and beat order.
module tb_write_stream_sequencer;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned STRIDE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [31:0] cmd_base_i = '0;
    logic [15:0] cmd_count_i = '0;
    logic        data_valid_i = 1'b0;
    logic        data_ready_o;
    logic [31:0] data_i = '0;
    logic        fsm_req_o;
    logic [31:0] fsm_adress_o;
    logic [31:0] fsm_data_o;
    logic        fsm_ack_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    write_stream_sequencer #(.DEPTH(DEPTH), .STRIDE(STRIDE)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_base_i(cmd_base_i), .cmd_count_i(cmd_count_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
        .fsm_req_o(fsm_req_o), .fsm_adress_o(fsm_adress_o), .fsm_data_o(fsm_data_o),
        .fsm_ack_i(fsm_ack_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Writer model: acks ack_delay cycles after seeing a request and logs the write.
    logic        ack_w = 1'b0;
    logic        ack_stray = 1'b0;
    bit          ack_en = 1'b1;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          done_cnt = 0;
    int          req_rises = 0;
    logic        req_q = 1'b0;
    logic [31:0] got_a[$];
    logic [31:0] got_d[$];
    logic [31:0] beats_q[$];

    assign fsm_ack_i = ack_w | ack_stray;

    always @(negedge clk) begin
        if (!rst_n) begin
            ack_w = 1'b0;
            wait_cnt = 0;
        end else if (ack_w) begin
            ack_w = 1'b0;
            wait_cnt = 0;
        end else if (fsm_req_o && ack_en) begin
            if (wait_cnt >= ack_delay) begin
                ack_w = 1'b1;
                got_a.push_back(fsm_adress_o);
                got_d.push_back(fsm_data_o);
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        if (done_o) done_cnt++;
        if (fsm_req_o && !req_q) req_rises++;
        req_q = fsm_req_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Runs one command from beats_q; optionally withholds acks for stall cycles first.
    task automatic run_cmd(input logic [31:0] base, input int count, input int valid_pct,
                           input int stall, input string tag);
        int   idx = 0;
        int   cyc = 0;
        bit   acc_pend = 1'b0;
        bit   bad_ready = 1'b0;
        int   start_done;
        logic [31:0] exp_a;
        got_a.delete();
        got_d.delete();
        start_done = done_cnt;
        if (stall > 0) ack_en = 1'b0;
        @(negedge clk);
        chk({tag, ".cmd_ready"}, 32'(cmd_ready_o), 32'd1);
        cmd_valid_i = 1'b1;
        cmd_base_i  = base;
        cmd_count_i = 16'(count);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        chk({tag, ".busy_after_cmd"}, 32'(busy_o), 32'(count != 0));
        while (!done_o && cyc < 2000) begin
            if (acc_pend) idx++;
            if (idx == count && data_ready_o) bad_ready = 1'b1;
            if (stall > 0 && cyc == stall) begin
                chk({tag, ".stall_accepted"}, 32'(idx), 32'(DEPTH));
                chk({tag, ".stall_ready"}, 32'(data_ready_o), 32'd0);
                ack_en = 1'b1;
            end
            if (idx < count && $urandom_range(99) < valid_pct) begin
                data_valid_i = 1'b1;
                data_i = beats_q[idx];
            end else begin
                data_valid_i = 1'b0;
                data_i = $urandom;
            end
            acc_pend = data_valid_i && data_ready_o;
            @(negedge clk);
            cyc++;
        end
        data_valid_i = 1'b0;
        ack_en = 1'b1;
        chk({tag, ".no_timeout"}, 32'(cyc < 2000), 32'd1);
        chk({tag, ".done_pulse"}, 32'(done_o), 32'd1);
        chk({tag, ".busy_in_done"}, 32'(busy_o), 32'd0);
        chk({tag, ".beats_accepted"}, 32'(idx), 32'(count));
        @(negedge clk);
        chk({tag, ".done_one_cycle"}, 32'(done_o), 32'd0);
        chk({tag, ".cmd_ready_again"}, 32'(cmd_ready_o), 32'd1);
        chk({tag, ".done_count"}, 32'(done_cnt - start_done), 32'd1);
        chk({tag, ".ready_after_last"}, 32'(bad_ready), 32'd0);
        chk({tag, ".err"}, 32'(err_o), 32'd0);
        chk({tag, ".write_count"}, 32'(got_a.size()), 32'(count));
        for (int i = 0; i < count && i < got_a.size(); i++) begin
            exp_a = base + 32'(i) * 32'(STRIDE);
            chk({tag, ".addr"}, got_a[i], exp_a);
            chk({tag, ".data"}, got_d[i], beats_q[i]);
        end
    endtask

    initial begin
        int rises;
        int dc;
        int cyc;
        repeat (2) @(negedge clk);
        chk("rst.cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("rst.req", 32'(fsm_req_o), 32'd0);
        chk("rst.addr", fsm_adress_o, 32'd0);
        chk("rst.data", fsm_data_o, 32'd0);
        chk("rst.data_ready", 32'(data_ready_o), 32'd0);
        chk("rst.busy", 32'(busy_o), 32'd0);
        chk("rst.done", 32'(done_o), 32'd0);
        chk("rst.err", 32'(err_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic three-beat command with acks two cycles after each request.
        ack_delay = 2;
        beats_q = '{32'hA, 32'hB, 32'hC};
        run_cmd(32'h0000_1000, 3, 100, 0, "basic");

        // Zero-count command: done without any request.
        rises = req_rises;
        beats_q.delete();
        run_cmd(32'h0000_5000, 0, 100, 0, "zero");
        chk("zero.no_req", 32'(req_rises - rises), 32'd0);

        // Backpressure with acks withheld.
        ack_delay = 0;
        beats_q.delete();
        for (int i = 0; i < 8; i++) beats_q.push_back(32'h100 + 32'(i));
        run_cmd(32'h0000_2000, 8, 100, 20, "bp");

        // Address wrap.
        ack_delay = 1;
        beats_q = '{32'h1111_1111, 32'h2222_2222};
        run_cmd(32'hFFFF_FFFC, 2, 100, 0, "wrap");

        // Stray ack in IDLE.
        dc = done_cnt;
        ack_stray = 1'b1;
        @(negedge clk);
        ack_stray = 1'b0;
        chk("stray.err_set", 32'(err_o), 32'd1);
        repeat (3) @(negedge clk);
        chk("stray.err_sticky", 32'(err_o), 32'd1);
        chk("stray.cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("stray.busy", 32'(busy_o), 32'd0);
        chk("stray.req", 32'(fsm_req_o), 32'd0);
        chk("stray.no_done", 32'(done_cnt - dc), 32'd0);
        beats_q = '{32'hDEAD_BEEF};
        run_cmd(32'h0000_3000, 1, 100, 0, "after_stray");

        // Reset asserted mid-run while a request is outstanding.
        ack_en = 1'b0;
        @(negedge clk);
        cmd_valid_i = 1'b1;
        cmd_base_i  = 32'h0000_4000;
        cmd_count_i = 16'd3;
        @(negedge clk);
        cmd_valid_i  = 1'b0;
        data_valid_i = 1'b1;
        data_i       = 32'h0BAD_F00D;
        cyc = 0;
        while (!fsm_req_o && cyc < 20) begin
            @(negedge clk);
            data_valid_i = 1'b0;
            cyc++;
        end
        data_valid_i = 1'b0;
        chk("rstmid.req_seen", 32'(fsm_req_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid.req", 32'(fsm_req_o), 32'd0);
        chk("rstmid.busy", 32'(busy_o), 32'd0);
        chk("rstmid.data_ready", 32'(data_ready_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_en = 1'b1;
        @(negedge clk);
        chk("rstmid.cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("rstmid.err", 32'(err_o), 32'd0);
        beats_q = '{32'h1234_5678};
        run_cmd(32'h0000_6000, 1, 100, 0, "after_rst");

        // Randomized commands.
        for (int n = 0; n < 8; n++) begin
            int cnt;
            cnt = int'($urandom_range(1, 12));
            ack_delay = int'($urandom_range(0, 3));
            beats_q.delete();
            for (int i = 0; i < cnt; i++) beats_q.push_back($urandom);
            run_cmd($urandom, cnt, int'($urandom_range(40, 100)), 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
